// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the serial link UART blocks.
// Contents:
//   parity_t              - parity select encoding (11 is treated as none)
//   tx_state_t            - transmitter frame states
//   UART_BAUD_DIV_DEFAULT - clocks per bit for 50 MHz / 9600 baud
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_BAUD_DIV_DEFAULT = 5208;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period timer shared by the UART transmitter and receiver. Counts
// 0..BAUD_DIV-1 while enabled and pulses bit_tick on the last count, so
// every bit period is exactly BAUD_DIV clocks with no drift.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   clr      - restart the count at 0 (start of a frame)
//   en       - count while high; held at 0 while low
//   bit_tick - one-cycle pulse when the count is BAUD_DIV-1
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, then wrap at the end of a bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = en && !clr && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Runtime-configurable UART transmitter: LSB-first data, optional even/odd
// parity and one or two stop bits chosen per frame. Frame settings are
// captured on the accepting edge so later input changes cannot disturb the
// frame in flight.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (forces TX high immediately)
//   trmt     - transmit request, only honoured in IDLE
//   tx_data  - word to send
//   par_mode - 00 none, 01 even, 10 odd, 11 none
//   two_stop - 1 selects two stop bits
//   TX       - registered serial line, idles high
//   tx_done  - set at frame end, held until the next accepted request
//   busy     - high while a frame is being sent
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        par_mode,
  input  logic              two_stop,
  output logic              TX,
  output logic              tx_done,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_t         state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [BCW-1:0]    bitCnt_q,  bitCnt_d;
  logic              stopCnt_q, stopCnt_d;
  logic              parEn_q,   parEn_d;
  logic              parBit_q,  parBit_d;
  logic              twoStop_q, twoStop_d;
  logic              tx_q,      tx_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;

  logic              baudClr;
  logic              bitTick;
  logic [DATA_W-1:0] shiftNext;

  // Bit-period timer runs only while a frame is in progress.
  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (baudClr),
    .en      (state_q != IDLE),
    .bit_tick(bitTick)
  );

  // Next-state and next-output logic. TX is computed one step ahead so the
  // line value changes on the same edge as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    parEn_d   = parEn_q;
    parBit_d  = parBit_q;
    twoStop_d = twoStop_q;
    tx_d      = tx_q;
    done_d    = done_q;
    busy_d    = busy_q;
    baudClr   = 1'b0;
    shiftNext = shift_q >> 1;

    case (state_q)
      IDLE: begin
        if (trmt) begin
          state_d   = START;
          shift_d   = tx_data;
          parEn_d   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
          // Parity is fixed from the latched word, so compute it once here.
          parBit_d  = (par_mode == PAR_ODD) ? ~(^tx_data) : ^tx_data;
          twoStop_d = two_stop;
          bitCnt_d  = '0;
          stopCnt_d = 1'b0;
          tx_d      = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          baudClr   = 1'b1;
        end
      end

      START: begin
        if (bitTick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bitTick) begin
          shift_d  = shiftNext;
          bitCnt_d = bitCnt_q + BCW'(1);
          if (bitCnt_q == LAST_BIT) begin
            if (parEn_q) begin
              state_d = PARITY;
              tx_d    = parBit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shiftNext[0];
          end
        end
      end

      PARITY: begin
        if (bitTick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bitTick) begin
          if (twoStop_q && !stopCnt_q) begin
            stopCnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      parEn_q   <= 1'b0;
      parBit_q  <= 1'b0;
      twoStop_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      parEn_q   <= parEn_d;
      parBit_q  <= parBit_d;
      twoStop_q <= twoStop_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign TX      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg with BAUD_DIV=16: an 8-bit instance for
// most frames and a 7-bit instance for the narrow-word, two-stop frame.
module tb_uart_tx_cfg;

  localparam int BD = 16;

  typedef struct {
    logic [8:0]  data;
    logic [1:0]  parMode;
    logic        twoStop;
    logic [15:0] frame;
    int          nBits;
    int          injAt;
    logic        sel7;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       trmt8, twoStop8, TX8, done8, busy8;
  logic [7:0] txData8;
  logic [1:0] parMode8;

  logic       trmt7, twoStop7, TX7, done7, busy7;
  logic [6:0] txData7;
  logic [1:0] parMode7;

  int testsRun  = 0;
  int failCount = 0;

  vec_t vecs[9];

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(BD)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt8),
    .tx_data (txData8),
    .par_mode(parMode8),
    .two_stop(twoStop8),
    .TX      (TX8),
    .tx_done (done8),
    .busy    (busy8)
  );

  uart_tx_cfg #(.DATA_W(7), .BAUD_DIV(BD)) dut7 (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt7),
    .tx_data (txData7),
    .par_mode(parMode7),
    .two_stop(twoStop7),
    .TX      (TX7),
    .tx_done (done7),
    .busy    (busy7)
  );

  // One comparison; counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requests a frame and waits for the accepting edge, then sampling point.
  task automatic applyStimulus(input vec_t v);
    if (v.sel7) begin
      txData7  = v.data[6:0];
      parMode7 = v.parMode;
      twoStop7 = v.twoStop;
      trmt7    = 1'b1;
    end else begin
      txData8  = v.data[7:0];
      parMode8 = v.parMode;
      twoStop8 = v.twoStop;
      trmt8    = 1'b1;
    end
    @(posedge clk); #1;
    trmt7 = 1'b0;
    trmt8 = 1'b0;
  endtask

  // Sends one frame and checks every clock of it against the expected bits.
  task automatic runFrame(input vec_t v, input string tag);
    int   n;
    logic seen, txNow, busyNow, doneNow, busyOk, doneOk;
    n      = v.nBits * BD;
    seen   = 1'b0;
    busyOk = 1'b1;
    doneOk = 1'b1;
    applyStimulus(v);
    for (int c = 0; c < n; c++) begin
      txNow   = v.sel7 ? TX7   : TX8;
      busyNow = v.sel7 ? busy7 : busy8;
      doneNow = v.sel7 ? done7 : done8;
      if (c % BD == 0) seen = v.frame[c / BD];
      if (txNow !== v.frame[c / BD]) seen = txNow;
      if (busyNow !== 1'b1) busyOk = 1'b0;
      if (doneNow !== 1'b0) doneOk = 1'b0;
      if (c % BD == BD - 1)
        checkOutput($sformatf("%s bit%0d", tag, c / BD), 16'(seen),
                    16'(v.frame[c / BD]));
      if (c == v.injAt) begin
        txData8  = 8'h3C;
        parMode8 = 2'b01;
        twoStop8 = 1'b1;
        trmt8    = 1'b1;
      end
      if (c == v.injAt + 1) trmt8 = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput({tag, " busy"}, 16'(busyOk), 16'd1);
    checkOutput({tag, " doneEarly"}, 16'(doneOk), 16'd1);
    if (v.sel7)
      checkOutput({tag, " end"}, 16'({TX7, busy7, done7}), 16'b101);
    else
      checkOutput({tag, " end"}, 16'({TX8, busy8, done8}), 16'b101);
  endtask

  initial begin : main
    int   rise2, rise3, rises;
    logic prevBusy;
    vec_t v5A;

    vecs[0] = '{9'h0A5, 2'b00, 1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1, 1'b0};
    vecs[1] = '{9'h0A5, 2'b01, 1'b0, 16'({2'b10, 8'hA5, 1'b0}), 11, -1, 1'b0};
    vecs[2] = '{9'h0A4, 2'b10, 1'b0, 16'({2'b10, 8'hA4, 1'b0}), 11, -1, 1'b0};
    vecs[3] = '{9'h0A5, 2'b10, 1'b0, 16'({2'b11, 8'hA5, 1'b0}), 11, -1, 1'b0};
    vecs[4] = '{9'h03C, 2'b00, 1'b1, 16'({2'b11, 8'h3C, 1'b0}), 11, -1, 1'b0};
    vecs[5] = '{9'h05A, 2'b11, 1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10, -1, 1'b0};
    vecs[6] = '{9'h001, 2'b01, 1'b0, 16'({2'b11, 8'h01, 1'b0}), 11, -1, 1'b0};
    vecs[7] = '{9'h0A5, 2'b00, 1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 50, 1'b0};
    vecs[8] = '{9'h041, 2'b00, 1'b1, 16'({2'b11, 7'h41, 1'b0}), 10, -1, 1'b1};
    v5A     = '{9'h05A, 2'b00, 1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10, -1, 1'b0};

    trmt8 = 1'b0; txData8 = '0; parMode8 = '0; twoStop8 = 1'b0;
    trmt7 = 1'b0; txData7 = '0; parMode7 = '0; twoStop7 = 1'b0;
    rst_n = 1'b0;

    // Reset then idle: line high, not busy, not done.
    for (int i = 0; i < 25; i++) begin
      if (i == 5) rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("idle%0d", i),
                  16'({TX8, busy8, done8, TX7, busy7, done7}), 16'b100100);
    end

    // Table of frames, back to back with one idle clock between them.
    for (int i = 0; i < 9; i++) begin
      runFrame(vecs[i], $sformatf("vec%0d", i));
    end

    // Held request: accepts at k, k+161, k+322.
    txData8 = 8'hA5; parMode8 = 2'b00; twoStop8 = 1'b0; trmt8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("held rise1", 16'(busy8), 16'd1);
    rise2 = -1; rise3 = -1; rises = 0; prevBusy = busy8;
    for (int t = 1; t <= 490; t++) begin
      @(posedge clk); #1;
      if (busy8 && !prevBusy) begin
        rises++;
        if (rises == 1) rise2 = t;
        if (rises == 2) rise3 = t;
      end
      prevBusy = busy8;
      if (t == 330) trmt8 = 1'b0;
    end
    checkOutput("held rise2", 16'(rise2), 16'd161);
    checkOutput("held rise3", 16'(rise3), 16'd322);
    checkOutput("held rises", 16'(rises), 16'd2);
    checkOutput("held end", 16'({TX8, busy8, done8}), 16'b101);

    // Mid-frame reset during data bit 3 (a 0 for 8'hA5).
    @(posedge clk); #1;
    applyStimulus(vecs[0]);
    repeat (70) begin @(posedge clk); #1; end
    checkOutput("rst preTX", 16'(TX8), 16'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async", 16'({TX8, busy8, done8}), 16'b100);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst held", 16'({TX8, busy8, done8}), 16'b100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runFrame(v5A, "post5A");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter that replaces the fixed 8N1 transmitter in the serial link path. It serialises one word per `trmt` request, LSB first. Data width and baud divisor are set by parameter; parity mode and stop-bit count are selected per frame. It reports completion and busy status to the host-side control logic.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5–9.
- `BAUD_DIV`, default 5208: clocks per bit (50 MHz / 9600 baud), minimum 4.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `trmt`  in  1  transmit request; sampled only in IDLE.
- `tx_data`  in  DATA_W  word to send; latched on the accepting edge.
- `par_mode`  in  2  parity select: 00 none, 01 even, 10 odd, 11 treated as none; latched with data.
- `two_stop`  in  1  1 = two stop bits, 0 = one stop bit; latched with data.
- `TX`  out  1  serial line; idles high.
- `tx_done`  out  1  set when a frame completes; held until the next accepted `trmt`.
- `busy`  out  1  high from the accepting edge until the frame ends.

## Operation
- Reset values: `TX`=1, `tx_done`=0, `busy`=0, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame at once and drives `TX` high asynchronously.
- States and transitions:
  - IDLE → START: on an edge with `trmt`=1.
  - START → DATA → PARITY (only if parity enabled) → STOP → IDLE.
- Accept edge:
  - Latch `tx_data`, `par_mode` and `two_stop`.
  - Clear `tx_done`, set `busy`, clear the baud counter.
- Each bit lasts exactly `BAUD_DIV` clocks, counted by the baud counter (0..BAUD_DIV-1); the state or shift advances when the count reaches BAUD_DIV-1.
- Bit values:
  - START drives 0.
  - DATA drives shift-register bit 0; the register shifts right once per bit, for DATA_W bits, tracked by a bit counter of width $clog2(DATA_W+1).
  - PARITY drives XOR-reduce of the latched data for even mode, its inverse for odd mode.
  - STOP drives 1 for 1 or 2 bit periods.
- `TX` is registered, with no combinational path from the inputs.
- `trmt` outside IDLE is ignored, including a `trmt` in the final cycle of STOP; a held-high `trmt` starts a new frame on the first IDLE edge.
- Input changes after the accept edge do not affect the frame in flight.

## Timing
- Accept edge k: `TX` goes low and `busy` goes high after edge k.
- Frame length: N = (1 + DATA_W + P + S) × BAUD_DIV clocks, where P ∈ {0,1} and S ∈ {1,2}.
- At edge k+N: `TX` stays 1, `busy` falls, `tx_done` rises, state returns to IDLE.
- Earliest next accept is edge k+N+1; the minimum inter-frame gap is 1 clock of idle-high.
- Every bit boundary falls exactly `BAUD_DIV` clocks after the previous one, with no cumulative drift.

## Structure
- Shared package `uart_pkg`:
  - `parity_t` enum: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10.
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Constant `UART_BAUD_DIV_DEFAULT`=5208.
- One natural sub-module, `uart_baud_gen`:
  - Parameter `BAUD_DIV`; inputs `clr` and `en`; output `bit_tick`, a one-cycle pulse at count BAUD_DIV-1.
  - Later reused by the receiver.
- Top level contains the FSM, shift register, bit counter, parity bit and stop counter.

## Test plan
All scenarios use BAUD_DIV=16 unless noted.
- Reset and idle: `rst_n` low for 5 clocks, then high for 20 clocks → `TX`=1, `busy`=0 and `tx_done`=0 throughout.
- 8N1 frame: `tx_data`=8'hA5, `par_mode`=00, `two_stop`=0, one-cycle `trmt` → `TX` sequence 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks; `tx_done` rises exactly 160 clocks after the accept edge.
- Parity: 8'hA5 with even parity → parity bit 0, frame 176 clocks; 8'hA4 with odd parity → parity bit 0; 8'hA5 with odd parity → parity bit 1.
- Two stop bits plus `DATA_W`=7: `tx_data`=7'h41, no parity, `two_stop`=1 → 10 bits, 160 clocks, with the final 32 clocks high.
- Busy handling:
  - Pulse `trmt` with 8'h3C at clock 50 of an in-flight frame → ignored, first frame unchanged.
  - Hold `trmt` high → frames start at edges k, k+161, k+322.
- Mid-frame reset: assert `rst_n`=0 during DATA bit 3 → `TX`=1 immediately (before the next clock edge), `busy`=0, `tx_done`=0; after release, a new 8'h5A frame is transmitted correctly.
